// File: rtl/dmem_responder_if.sv
// CPU data-memory port bundle: request fields from the CPU, response back
// from the responder.
interface dmem_if;
  logic        req;
  logic        DM_W;
  logic [1:0]  DMS_mux;
  logic [2:0]  DML_mux;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, DM_W, DMS_mux, DML_mux, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, DM_W, DMS_mux, DML_mux, addr, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time over a
// req/ready handshake, sub-word stores by read-modify-write on a word array.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic   clk_in,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  store_q, store_d;
  logic [1:0]            dms_q, dms_d;
  logic [2:0]            dml_q, dml_d;
  logic [1:0]            off_q, off_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           buf_q;

  logic                  accept, is_word, is_half, illegal;
  logic                  mem_we, mem_re;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_wdata;
  logic                  unused_addr;

  assign unused_addr = ^bus.addr[31:DEPTH_LOG2+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  mode,
                                              input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (mode)
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = {16'h0000, h};
      3'b011:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h000000, b};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    if (size == 2'b01)
      res[{off[1], 4'b0000} +: 16] = wd[15:0];
    else if (size == 2'b10)
      res[{off, 3'b000} +: 8] = wd[7:0];
    return res;
  endfunction

  // Request decode; reset gates acceptance so no array access happens while held.
  always_comb begin
    accept  = (state_q == S_IDLE) && bus.req && reset;
    is_word = bus.DM_W ? (bus.DMS_mux == 2'b00) : (bus.DML_mux == 3'b000);
    is_half = bus.DM_W ? (bus.DMS_mux == 2'b01)
                       : ((bus.DML_mux == 3'b001) || (bus.DML_mux == 3'b010));
    illegal = (bus.DM_W ? (bus.DMS_mux == 2'b11) : (bus.DML_mux > 3'd4)) ||
              (is_word && (bus.addr[1:0] != 2'b00)) ||
              (is_half && bus.addr[0]);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = store_merge(buf_q, wdata_q, dms_q, off_q);
    if (accept && !illegal) begin
      mem_idx = bus.addr[DEPTH_LOG2+1:2];
      if (bus.DM_W && is_word) begin
        mem_we    = 1'b1;
        mem_wdata = bus.wdata;
      end else begin
        mem_re = 1'b1;
      end
    end else if ((state_q == S_RD) && store_q) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    dms_d   = dms_q;
    dml_d   = dml_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          store_d = bus.DM_W;
          dms_d   = bus.DMS_mux;
          dml_d   = bus.DML_mux;
          off_d   = bus.addr[1:0];
          idx_d   = bus.addr[DEPTH_LOG2+1:2];
          wdata_d = bus.wdata;
          err_d   = illegal;
          state_d = (illegal || (bus.DM_W && is_word)) ? S_RESP : S_RD;
        end
      end
      S_RD: begin
        if (!store_q)
          rdata_d = load_extend(buf_q, dml_q, off_q);
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      dms_q   <= 2'b00;
      dml_q   <= 3'b000;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      dms_q   <= dms_d;
      dml_q   <= dml_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array and its read buffer carry no reset so they map onto block RAM.
  always_ff @(posedge clk_in) begin
    if (mem_we)
      mem[mem_idx] <= mem_wdata;
    if (mem_re)
      buf_q <= mem[mem_idx];
  end

  assign bus.ready = (state_q == S_RESP);
  assign bus.err   = (state_q == S_RESP) && err_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: word/sub-word stores, load extension,
// rejects, handshake timing and reset during a read-modify-write.
module tb_dmem_responder;
  logic clk_in;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_rd;

  dmem_if bus ();

  dmem_responder #(.DEPTH_LOG2(11)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble inputs after the accept edge, then check
  // latency, err and rdata on the ready cycle and ready low afterwards.
  task automatic xfer(input string tag, input logic st, input logic [1:0] dms,
                      input logic [2:0] dml, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk_in);
    bus.req     = 1'b1;
    bus.DM_W    = st;
    bus.DMS_mux = dms;
    bus.DML_mux = dml;
    bus.addr    = a;
    bus.wdata   = wd;
    @(posedge clk_in);
    #1;
    bus.req     = 1'b0;
    bus.DM_W    = ~st;
    bus.DMS_mux = ~dms;
    bus.DML_mux = ~dml;
    bus.addr    = ~a;
    bus.wdata   = ~wd;
    lat = 1;
    while (!bus.ready && lat < 6) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " err"}, {31'h0, bus.err}, {31'h0, exp_err});
    chk({tag, " rdata"}, bus.rdata, exp_rd);
    @(posedge clk_in);
    #1;
    chk({tag, " ready drop"}, {31'h0, bus.ready}, 32'h0);
  endtask

  task automatic ld(input string tag, input logic [2:0] dml, input logic [31:0] a,
                    input logic [31:0] exp);
    xfer(tag, 1'b0, 2'b00, dml, a, 32'h0, 2, 1'b0, exp);
    last_rd = exp;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    last_rd     = 32'h0;
    reset       = 1'b0;
    bus.req     = 1'b0;
    bus.DM_W    = 1'b0;
    bus.DMS_mux = 2'b00;
    bus.DML_mux = 3'b000;
    bus.addr    = 32'h0;
    bus.wdata   = 32'h0;
    #1;
    chk("in reset ready", {31'h0, bus.ready}, 32'h0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    chk("reset ready", {31'h0, bus.ready}, 32'h0);
    chk("reset err", {31'h0, bus.err}, 32'h0);
    chk("reset rdata", bus.rdata, 32'h0);

    xfer("sw 10", 1'b1, 2'b00, 3'b000, 32'h10, 32'hDEADBEEF, 1, 1'b0, last_rd);
    ld("lw 10", 3'b000, 32'h10, 32'hDEADBEEF);
    xfer("sb 11", 1'b1, 2'b10, 3'b000, 32'h11, 32'hFFFFFF5A, 2, 1'b0, last_rd);
    ld("lw 10 after sb", 3'b000, 32'h10, 32'hDEAD5AEF);
    xfer("sh 12", 1'b1, 2'b01, 3'b000, 32'h12, 32'hABCD1234, 2, 1'b0, last_rd);
    ld("lw 10 after sh", 3'b000, 32'h10, 32'h12345AEF);

    xfer("sw 20", 1'b1, 2'b00, 3'b000, 32'h20, 32'h80FF7F01, 1, 1'b0, last_rd);
    ld("lb 22", 3'b011, 32'h22, 32'hFFFFFFFF);
    ld("lbu 22", 3'b100, 32'h22, 32'h000000FF);
    ld("lh 22", 3'b001, 32'h22, 32'hFFFF80FF);
    ld("lhu 20", 3'b010, 32'h20, 32'h00007F01);
    ld("lb 20", 3'b011, 32'h20, 32'h00000001);

    xfer("rej lw 21", 1'b0, 2'b00, 3'b000, 32'h21, 32'h0, 1, 1'b1, last_rd);
    xfer("rej sh 23", 1'b1, 2'b01, 3'b000, 32'h23, 32'h55555555, 1, 1'b1, last_rd);
    xfer("rej dms 11", 1'b1, 2'b11, 3'b000, 32'h20, 32'h66666666, 1, 1'b1, last_rd);
    xfer("rej dml 110", 1'b0, 2'b00, 3'b110, 32'h20, 32'h0, 1, 1'b1, last_rd);
    ld("lw 20 after rej", 3'b000, 32'h20, 32'h80FF7F01);

    // req held high: pattern RD, RESP, IDLE repeats, ready only in RESP.
    @(negedge clk_in);
    bus.req     = 1'b1;
    bus.DM_W    = 1'b0;
    bus.DML_mux = 3'b011;
    bus.addr    = 32'h22;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_in);
      #1;
      chk($sformatf("held req ready %0d", i), {31'h0, bus.ready},
          {31'h0, ((i % 3) == 1)});
    end
    bus.req = 1'b0;
    chk("held req rdata", bus.rdata, 32'hFFFFFFFF);
    last_rd = 32'hFFFFFFFF;

    // Reset asserted while a byte store sits in RD.
    @(negedge clk_in);
    bus.req     = 1'b1;
    bus.DM_W    = 1'b1;
    bus.DMS_mux = 2'b10;
    bus.addr    = 32'h10;
    bus.wdata   = 32'h000000AA;
    @(posedge clk_in);
    #1;
    bus.req = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst in RD ready", {31'h0, bus.ready}, 32'h0);
    @(posedge clk_in);
    #1;
    chk("rst held ready", {31'h0, bus.ready}, 32'h0);
    @(negedge clk_in);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in);
      #1;
      chk($sformatf("post rst ready %0d", i), {31'h0, bus.ready}, 32'h0);
    end
    chk("post rst rdata", bus.rdata, 32'h0);
    last_rd = 32'h0;
    ld("lw 10 after rst", 3'b000, 32'h10, 32'h12345AEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
